muladd_seq: RTL and testbench
=============================

Name: muladd_seq

Overview:
Multi-cycle multiply-accumulate unit sitting directly downstream of the ALU control decoder (alucontrol = 3'b101, MULADD) in the execute stage. It replaces the single-cycle combinational b*c+a path with an iterative radix-2 shift-add engine. While the operation runs it raises a stall request to the hazard controller, and it returns the low WIDTH bits of (b*c + a) to the execute result mux.

Parameters:
WIDTH, 32, operand and result width in bits
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset (reset==0 clears all state)
start  input  1  request; sampled only in IDLE; launches one MULADD
flush  input  1  synchronous abort (FlushE); returns to IDLE, no done
a  input  WIDTH  addend (ALU operand A)
b  input  WIDTH  multiplicand
c  input  WIDTH  multiplier
busy  output  1  high in BUSY and DONE states
stall_req  output  1  combinational: (start & IDLE) | BUSY; OR'd into StallF/StallD
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  (b*c + a) mod 2^WIDTH; held until next accepted start

Behaviour:
- Reset (async, reset==0): state=IDLE, acc=0, mcand=0, mplier=0, cnt=0, result=0, done=0, busy=0, stall_req=0.
- Arithmetic is unsigned and truncated to WIDTH bits; overflow bits are discarded silently.
- IDLE: on start=1 and flush=0, latch acc<=a, mcand<=b, mplier<=c, cnt<=0, then go to BUSY. Operands are captured only at this edge; later changes to a/b/c are ignored.
- BUSY, one iteration per cycle:
  - if mplier[0], acc<=acc+mcand;
  - mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1;
  - when cnt==WIDTH-1, go to DONE.
- DONE: result<=acc (registered), done=1 for exactly this cycle, then go to IDLE.
- Latency: start sampled at edge N; done high in cycle N+WIDTH+1 (33 cycles for WIDTH=32). No back-to-back issue: the next start is accepted no earlier than the cycle after done.
- stall_req:
  - asserted combinationally in the start cycle, so the pipeline freezes the instruction in place;
  - deasserted in the DONE cycle, so the frozen instruction consumes result on that edge.
- start while busy: ignored, no error.
- flush has priority over start and over all iterations. It returns to IDLE next edge, suppresses done, and leaves result unchanged.
- reset asserted mid-operation: immediate return to IDLE, all outputs 0.
- c==0: still runs the full WIDTH iterations (unless the optional feature below is enabled); result = a.

Optional Feature:
MULADD_EARLY_EXIT_EN
- Defined: BUSY also exits to DONE on the edge where the next mplier value is zero. Latency becomes 2 + index of the highest set bit of c; c==0 gives latency 2.
- Undefined: fixed latency WIDTH+1. Results are identical in both builds; only timing differs.

Decomposition:
- Shared package muladd_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} muladd_state_t;
  - localparam ALU_MULADD = 3'b101.
- One natural sub-module: muladd_step, the combinational single-iteration shift-add (acc, mcand, mplier -> next values), instantiated once.
- The FSM, counter and result register stay in muladd_seq.

Test Plan:
1. a=5, b=3, c=7, start pulse → stall_req=1 same cycle, done exactly 33 cycles later, result=26; stall_req=0 in the done cycle.
2. a=0, b=32'hFFFF_FFFF, c=2 → result=32'hFFFF_FFFE (truncation); a=1, b=32'h8000_0000, c=2 → result=1.
3. start held high continuously with a=1, b=2, c=3 → exactly one done per 34 cycles, result=7; extra starts during BUSY are ignored.
4. flush=1 at iteration 10 → IDLE next cycle, no done pulse, result keeps its prior value; a new start afterwards completes normally.
5. reset driven low asynchronously mid-BUSY (between clock edges) → busy, done, stall_req and result go to 0 immediately, with no clock edge needed.
6. With MULADD_EARLY_EXIT_EN defined: c=0, a=9 → done 2 cycles after start, result=9. c=1, b=4, a=0 → done 2 cycles after start, result=4. c=32'h8000_0000 → done 33 cycles after start.

Source files
------------

// File: rtl/muladd_pkg.sv
// rtl/muladd_pkg.sv - shared types and constants for the iterative multiply-accumulate unit
//
// Contents:
//   muladd_state_t : FSM encoding (IDLE, BUSY, DONE)
//   ALU_MULADD     : alucontrol code that routes an instruction to this unit

package muladd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muladd_state_t;

    localparam logic [2:0] ALU_MULADD = 3'b101;

endpackage

// File: rtl/muladd_step.sv
// rtl/muladd_step.sv - one radix-2 shift-add iteration of the multiply-accumulate engine
//
// Ports:
//   acc, mcand, mplier                : current accumulator, shifted multiplicand, shifted multiplier
//   acc_next, mcand_next, mplier_next : values after one iteration (purely combinational)

module muladd_step
    import muladd_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] mcand_next,
    output logic [WIDTH-1:0] mplier_next
);

    // Sum wraps at WIDTH bits; the carry out is dropped on purpose.
    assign acc_next    = mplier[0] ? (acc + mcand) : acc;
    assign mcand_next  = mcand << 1;
    assign mplier_next = mplier >> 1;

endmodule

// File: rtl/muladd_seq.sv
// rtl/muladd_seq.sv - multi-cycle unsigned b*c+a unit with pipeline stall request
//
// Optional build macro: MULADD_EARLY_EXIT_EN (finish as soon as the remaining multiplier is zero).
//
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   start     : launch request, sampled only in IDLE
//   flush     : synchronous abort, back to IDLE without done
//   a, b, c   : addend, multiplicand, multiplier
//   busy      : high in BUSY and DONE
//   stall_req : (start in IDLE) or BUSY
//   done      : one-cycle pulse, result valid
//   result    : (b*c + a) mod 2^WIDTH, held until the next completed operation

module muladd_seq
    import muladd_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    muladd_state_t    state;
    muladd_state_t    state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mcand_next;
    logic [WIDTH-1:0] mplier_next;
    logic             last_iter;
    logic             accept;

    muladd_step #(.WIDTH(WIDTH)) u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_next    (acc_next),
        .mcand_next  (mcand_next),
        .mplier_next (mplier_next)
    );

    assign accept = (state == IDLE) && start && !flush;

`ifdef MULADD_EARLY_EXIT_EN
    // Once no multiplier bits remain, further iterations cannot change acc.
    assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || (mplier_next == '0);
`else
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (flush) state_next = IDLE;
                     else if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // stall_req drops in DONE so the frozen instruction captures result on that edge.
    always_comb begin
        busy      = (state == BUSY) || (state == DONE);
        done      = (state == DONE);
        stall_req = (start && (state == IDLE)) || (state == BUSY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc    <= a;
                        mcand  <= b;
                        mplier <= c;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    if (!flush) begin
                        acc    <= acc_next;
                        mcand  <= mcand_next;
                        mplier <= mplier_next;
                        cnt    <= cnt + CNT_W'(1);
                        // Loaded on the edge into DONE so it is valid while done is high.
                        if (last_iter) begin
                            result <= acc_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muladd_seq.sv
// tb/tb_muladd_seq.sv - self-checking bench for muladd_seq

module tb_muladd_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] result;

    int          n_pass;
    int          n_total;
    logic [31:0] sb[$];

    muladd_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .flush     (flush),
        .a         (a),
        .b         (b),
        .c         (c),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    function automatic int exp_lat(input logic [31:0] cv);
`ifdef MULADD_EARLY_EXIT_EN
        int hi;
        hi = -1;
        for (int i = 0; i < 32; i++) if (cv[i]) hi = i;
        return (hi < 0) ? 2 : 2 + hi;
`else
        return 33;
`endif
    endfunction

    // Called at posedge+1 with the DUT in IDLE; returns in IDLE.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] ic,
                          input string tag);
        int          lat;
        logic [31:0] exp_r;
        a = ia; b = ib; c = ic; start = 1'b1;
        sb.push_back(ib * ic + ia);
        #1;
        chk({tag, "_stall_start"}, {31'b0, stall_req}, 32'd1);
        cyc();
        start = 1'b0;
        a = $urandom; b = $urandom; c = $urandom;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            cyc();
            lat++;
        end
        exp_r = sb.pop_front();
        chk({tag, "_latency"}, lat, exp_lat(ic));
        chk({tag, "_result"}, result, exp_r);
        chk({tag, "_stall_done"}, {31'b0, stall_req}, 32'd0);
        chk({tag, "_busy_done"}, {31'b0, busy}, 32'd1);
        cyc();
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int          ndone;
        int          last;
        int          nd;
        logic [31:0] exp_r;

        n_pass = 0; n_total = 0;
        reset = 1'b0; start = 1'b0; flush = 1'b0;
        a = '0; b = '0; c = '0;
        #3;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_stall", {31'b0, stall_req}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc();

        // Basic operation and operand capture
        run_op(32'd5, 32'd3, 32'd7, "t1");
        chk("t1_value", result, 32'd26);

        // Truncation
        run_op(32'd0, 32'hFFFF_FFFF, 32'd2, "t2a");
        chk("t2a_value", result, 32'hFFFF_FFFE);
        run_op(32'd1, 32'h8000_0000, 32'd2, "t2b");
        chk("t2b_value", result, 32'd1);

        // start held high: back-to-back accepts spaced by latency+1
        a = 32'd1; b = 32'd2; c = 32'd3; start = 1'b1;
        repeat (3) sb.push_back(32'd2 * 32'd3 + 32'd1);
        ndone = 0; last = 0;
        for (int i = 1; i <= 200 && ndone < 3; i++) begin
            cyc();
            if (done === 1'b1) begin
                exp_r = sb.pop_front();
                chk("t3_result", result, exp_r);
                chk("t3_gap", i - last, (ndone == 0) ? exp_lat(32'd3) : exp_lat(32'd3) + 1);
                last = i;
                ndone++;
                if (ndone == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("t3_count", ndone, 32'd3);
        cyc();
        chk("t3_idle", {31'b0, busy}, 32'd0);
        sb.delete();

        // Flush mid-operation
        a = 32'd10; b = 32'd20; c = 32'hF000_0001; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (10) cyc();
        chk("t4_busy_pre", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("t4_idle", {31'b0, busy}, 32'd0);
        chk("t4_done", {31'b0, done}, 32'd0);
        chk("t4_result_held", result, 32'd7);
        nd = 0;
        repeat (40) begin
            cyc();
            if (done === 1'b1) nd++;
        end
        chk("t4_no_done", nd, 32'd0);
        run_op(32'd10, 32'd20, 32'hF000_0001, "t4_after");

        // Asynchronous reset mid-BUSY
        a = 32'd1; b = 32'd1; c = 32'h8000_0001; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        chk("t5_busy_pre", {31'b0, busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_busy", {31'b0, busy}, 32'd0);
        chk("t5_done", {31'b0, done}, 32'd0);
        chk("t5_stall", {31'b0, stall_req}, 32'd0);
        chk("t5_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc();
        chk("t5_idle", {31'b0, busy}, 32'd0);

        // Early-exit vectors (latency expectation follows the build)
        run_op(32'd9, 32'd123, 32'd0, "t6a");
        chk("t6a_value", result, 32'd9);
        run_op(32'd0, 32'd4, 32'd1, "t6b");
        chk("t6b_value", result, 32'd4);
        run_op(32'd3, 32'd5, 32'h8000_0000, "t6c");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
